// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift engine: operation codes and FSM states.
package shift_pkg;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; the sequencer applies it once per clock.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [1:0]   op,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_comb begin
    q = d;
    unique case (op)
      OP_ROR: q = {d[0], d[N-1:1]};
      OP_SRL: q = {1'b0, d[N-1:1]};
      OP_SLL: q = {d[N-2:0], 1'b0};
      OP_SRA: q = {d[N-1], d[N-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: loads an operand on start, applies one bit step per clock for
// shamt clocks, then pulses done for one cycle with the result held on dataout.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [SHW-1:0] shamt,
  input  logic [N-1:0]   dataa,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   dataout
);

  // Handshake: start is accepted only on an edge where busy=0 (IDLE); while busy=1 start
  // and all operand inputs are ignored. done is a single-cycle pulse marking dataout valid,
  // and dataout then holds until the next accepted start.
  state_t         state;
  state_t         state_nxt;
  logic [SHW-1:0] count;
  logic [1:0]     op_q;
  logic [N-1:0]   step_q;
  logic           accept;

  assign accept = (state == IDLE) && start;

  shift_step #(.N(N)) u_step (
    .op (op_q),
    .d  (dataout),
    .q  (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (count == SHW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout <= '0;
      count   <= '0;
      op_q    <= OP_ROR;
    end else if (accept) begin
      dataout <= dataa;
      count   <= shamt;
      op_q    <= op;
    end else if (state == SHIFT) begin
      dataout <= step_q;
      count   <= count - SHW'(1);
    end
  end

  // Outputs decode from the state register only, so reset clears them without a clock edge.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed plan vectors, random ops, busy-start
// rejection, back-to-back starts and asynchronous reset mid-operation.
module tb_seq_shifter;

  localparam int N   = 8;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [SHW-1:0] shamt = '0;
  logic [N-1:0]   dataa = '0;
  logic           busy;
  logic           done;
  logic [N-1:0]   dataout;

  logic [N-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  seq_shifter #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .dataa   (dataa),
    .busy    (busy),
    .done    (done),
    .dataout (dataout)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model(input logic [1:0] o, input int s, input logic [N-1:0] d);
    logic [N-1:0] r;
    case (o)
      2'b00:   r = (d >> s) | (d << (N - s));
      2'b01:   r = d >> s;
      2'b10:   r = d << s;
      default: r = N'($signed(d) >>> s);
    endcase
    return r;
  endfunction

  // Runs one operation; poke=1 re-asserts start with different operands in cycle 2.
  task automatic run_op(input logic [1:0] o, input int s, input logic [N-1:0] d,
                        input logic [N-1:0] want, input bit poke, input bit check_idle_after);
    int cyc;
    logic [N-1:0] exp_v;
    @(negedge clk);
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_before_start: busy=%0b required 0", busy);
    end
    vectors++;
    start = 1'b1; op = o; shamt = SHW'(s); dataa = d;
    exp_q.push_back(want);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); shamt = SHW'($urandom_range(0, N-1)); dataa = N'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc <= N + 2) begin
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_during_shift: cycle %0d busy=%0b required 1", cyc, busy);
      end
      vectors++;
      @(negedge clk);
      cyc++;
      if (poke && cyc == 2) begin
        start = 1'b1; op = 2'b10; dataa = '0; shamt = SHW'($urandom_range(0, N-1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    vectors++;
    if (cyc != s + 1) begin
      miscompares++;
      $display("FAIL latency op=%0d shamt=%0d: done at cycle %0d required %0d", o, s, cyc, s + 1);
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (dataout !== exp_v) begin
      miscompares++;
      $display("FAIL result op=%0d shamt=%0d data=%h: got %h required %h", o, s, d, dataout, exp_v);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_in_done: busy=%0b required 1", busy);
    end
    if (check_idle_after) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || dataout !== exp_v) begin
        miscompares++;
        $display("FAIL hold_after_done: busy=%0b done=%0b dataout=%h required 0 0 %h",
                 busy, done, dataout, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; dataa = 8'hFF; op = 2'b01; shamt = 3'd3;
    repeat (3) @(negedge clk);
    vectors++;
    if (dataout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: dataout=%h busy=%0b done=%0b required 00 0 0", dataout, busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (dataout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: dataout=%h busy=%0b done=%0b required 00 0 0", dataout, busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(2'b01, 3, 8'hB4, 8'h16, 1'b0, 1'b1);
    run_op(2'b11, 2, 8'h90, 8'hE4, 1'b0, 1'b1);
    run_op(2'b00, 1, 8'h81, 8'hC0, 1'b0, 1'b1);
    run_op(2'b10, 7, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op(2'b01, 0, 8'h5A, 8'h5A, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0] o;
      int s;
      logic [N-1:0] d;
      o = 2'($urandom_range(0, 3));
      s = $urandom_range(0, N-1);
      d = N'($urandom);
      run_op(o, s, d, model(o, s, d), 1'b0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    run_op(2'b11, 4, 8'hA5, model(2'b11, 4, 8'hA5), 1'b0, 1'b0);
    run_op(2'b00, 6, 8'h3C, model(2'b00, 6, 8'h3C), 1'b0, 1'b0);
    run_op(2'b10, 0, 8'hC3, 8'hC3, 1'b0, 1'b1);
  endtask

  task automatic test_start_while_busy();
    run_op(2'b01, 5, 8'hFF, 8'h07, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    start = 1'b1; op = 2'b01; shamt = 3'd5; dataa = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dataout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_mid_op: dataout=%h busy=%0b done=%0b required 00 0 0", dataout, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || dataout !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%0b dataout=%h required 0 00", busy, dataout);
    end
    run_op(2'b10, 2, 8'h21, 8'h84, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
